uart_mmio: RTL and testbench

Memory-mapped UART peripheral that sits directly downstream of the data-bus decoder in the UART address window. It consumes the decoder's read/write strobes plus the low address bits and supplies the 32-bit read word the decoder muxes onto the CPU data path. The block contains a serial receiver feeding a 16-entry RX FIFO, a single-byte transmitter, and status and control registers.

---
 rtl/uart_mmio_pkg.sv | 44 ++++
 rtl/uart_mmio_if.sv | 16 +
 rtl/uart_mmio_rx_core.sv | 107 ++++++++++
 rtl/uart_mmio.sv | 212 +++++++++++++++++++++
 tb/tb_uart_mmio.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg: shared definitions for the memory-mapped UART.
//   - register selectors (addr[3:2]) for RXDATA/TXDATA/STATUS/CTRL
//   - STATUS and CTRL bit positions
//   - RX/TX state machine encodings
//   - baud divisor helper, rounded to nearest
package uart_mmio_pkg;

  localparam logic [1:0] REG_RXDATA = 2'd0;
  localparam logic [1:0] REG_TXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int unsigned ST_RX_FULL   = 8;
  localparam int unsigned ST_TX_BUSY   = 9;
  localparam int unsigned ST_OVERRUN   = 10;
  localparam int unsigned ST_FRAME_ERR = 11;
  localparam int unsigned ST_TX_DROP   = 12;

  localparam int unsigned CTRL_CLR_OVR  = 0;
  localparam int unsigned CTRL_CLR_FERR = 1;
  localparam int unsigned CTRL_CLR_DROP = 2;
  localparam int unsigned CTRL_FLUSH    = 3;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_mmio_if.sv
// uart_mmio_if: bus-decoder side of the UART window.
//   addr  : byte offset, [3:2] selects the register
//   ren   : one-cycle read strobe
//   wen   : one-cycle write strobe
//   wdata : write data
//   rdata : registered read data from the peripheral
interface uart_mmio_if;
  logic [3:0]  addr;
  logic        ren;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output ren, output wen, output wdata, input rdata);
  modport slave  (input addr, input ren, input wen, input wdata, output rdata);
endinterface

// File: rtl/uart_mmio_rx_core.sv
// uart_rx_core: serial receiver.
//   clk, rst_n   : core clock, async active-low reset
//   rx_i         : asynchronous serial input, idle high
//   byte_o       : received byte, valid while byte_valid_o is high
//   byte_valid_o : one-cycle pulse, good stop bit seen
//   frame_err_o  : one-cycle pulse, stop bit sampled low
module uart_rx_core
  import uart_mmio_pkg::*;
#(
  parameter int unsigned DIV = 234
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

  logic          sync1_q, sync2_q, prev_q;
  rx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          valid_q;
  logic          ferr_q;

  // prev_q lags the synchronized line by one cycle for falling-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (prev_q && !sync2_q) state_q <= RX_START;
        end
        RX_START: begin
          // mid-start re-sample rejects short glitches
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q <= '0;
            if (sync2_q) begin
              valid_q <= 1'b1;
              state_q <= RX_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= RX_WAIT;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_WAIT: begin
          if (sync2_q) state_q <= RX_IDLE;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART with 16-entry RX FIFO and single-byte TX.
//   clk, rst_n : core clock, async active-low reset
//   bus        : decoder strobes, address, write data, registered read data
//   uart_rx    : serial input (asynchronous, idle high)
//   uart_tx    : serial output (idle high)
//   rx_irq     : high while the RX FIFO holds data
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 27000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_mmio_if.slave bus,
  input  logic      uart_rx,
  output logic      uart_tx,
  output logic      rx_irq
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);
  localparam logic [AW:0]   DEPTH   = (AW + 1)'(FIFO_DEPTH);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx_core #(.DIV(DIV)) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (uart_rx),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_ferr)
  );

  logic [1:0] sel;
  logic       wr_tx, wr_ctrl;
  logic       unused_bus;

  assign sel        = bus.addr[3:2];
  assign wr_tx      = bus.wen && (sel == REG_TXDATA);
  assign wr_ctrl    = bus.wen && (sel == REG_CTRL);
  assign unused_bus = ^{bus.addr[1:0], bus.wdata[31:8]};

  // ---------------- RX FIFO ----------------
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full, pop, push_ok, flush;

  assign full    = (count_q == DEPTH);
  assign pop     = bus.ren && (sel == REG_RXDATA) && (count_q != '0);
  assign flush   = wr_ctrl && bus.wdata[CTRL_FLUSH];
  // a pop in the same cycle frees the slot the push needs
  assign push_ok = rx_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rx_irq = (count_q != '0);

  // ---------------- TX ----------------
  tx_state_e     tx_state_q;
  logic          tx_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          tx_busy;

  assign tx_busy = (tx_state_q != TX_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_q       <= 1'b1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_cnt_q <= '0;
          if (wr_tx) begin
            tx_state_q <= TX_START;
            tx_q       <= 1'b0;
            tx_shift_q <= bus.wdata[7:0];
          end
        end
        TX_START: begin
          if (tx_cnt_q == FULL_M1) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == FULL_M1) begin
            tx_cnt_q   <= '0;
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_bit_q   <= tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_q <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == FULL_M1) begin
            tx_cnt_q   <= '0;
            tx_state_q <= TX_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        default: begin
          tx_state_q <= TX_IDLE;
          tx_q       <= 1'b1;
        end
      endcase
    end
  end

  assign uart_tx = tx_q;

  // ---------------- sticky flags ----------------
  logic ovr_q, ovr_d, ferr_q, ferr_d, drop_q, drop_d;

  // a same-cycle set event beats the CTRL clear
  always_comb begin
    ovr_d  = ovr_q  && !(wr_ctrl && bus.wdata[CTRL_CLR_OVR]);
    ferr_d = ferr_q && !(wr_ctrl && bus.wdata[CTRL_CLR_FERR]);
    drop_d = drop_q && !(wr_ctrl && bus.wdata[CTRL_CLR_DROP]);
    if (rx_valid && full && !pop && !flush) ovr_d = 1'b1;
    if (rx_ferr) ferr_d = 1'b1;
    if (wr_tx && tx_busy) drop_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
      drop_q <= drop_d;
    end
  end

  // ---------------- read path ----------------
  logic [31:0] status, rd_word, rdata_q;

  always_comb begin
    status               = '0;
    status[AW:0]         = count_q;
    status[ST_RX_FULL]   = full;
    status[ST_TX_BUSY]   = tx_busy;
    status[ST_OVERRUN]   = ovr_q;
    status[ST_FRAME_ERR] = ferr_q;
    status[ST_TX_DROP]   = drop_q;
  end

  always_comb begin
    rd_word = '0;
    case (sel)
      REG_RXDATA: if (count_q != '0) rd_word = {23'b0, 1'b1, mem_q[rd_ptr_q]};
      REG_STATUS: rd_word = status;
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rdata_q <= '0;
    else if (bus.ren) rdata_q <= rd_word;
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_uart_mmio.sv
module tb_uart_mmio;

  localparam int DIV  = 234;
  localparam int HALF = DIV / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rx = 1'b1;
  logic uart_tx;
  logic rx_irq;
  int   cyc = 0;

  uart_mmio_if bus();

  uart_mmio #(.CLK_HZ(27000000), .BAUD(115200), .FIFO_DEPTH(16)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .rx_irq  (rx_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] sb[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [31:0] st(input int cnt, input bit ovr, input bit ferr,
                                     input bit drop, input bit busy);
    logic [31:0] s;
    s = 32'(cnt);
    s[8]  = (cnt == 16);
    s[9]  = busy;
    s[10] = ovr;
    s[11] = ferr;
    s[12] = drop;
    return s;
  endfunction

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.addr = a;
    bus.ren  = 1'b1;
    @(posedge clk);
    #1;
    bus.ren = 1'b0;
    d = bus.rdata;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.addr  = a;
    bus.wdata = d;
    bus.wen   = 1'b1;
    @(posedge clk);
    #1;
    bus.wen = 1'b0;
  endtask

  task automatic read_status(input string name, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(4'h8, d);
    check(name, d, exp);
  endtask

  task automatic read_rx(input string name);
    logic [31:0] d, e;
    e = (sb.size() != 0) ? sb.pop_front() : 32'h0;
    bus_read(4'h0, d);
    check(name, d, e);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (DIV) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  txb;
    int          e;
    bit          found;

    tbl[0] = '{1'b0, 4'h0, 32'h0,    32'h0};
    tbl[1] = '{1'b0, 4'h4, 32'h0,    32'h0};
    tbl[2] = '{1'b0, 4'h8, 32'h0,    32'h0};
    tbl[3] = '{1'b0, 4'hC, 32'h0,    32'h0};
    tbl[4] = '{1'b1, 4'h0, 32'h41,   32'h0};
    tbl[5] = '{1'b0, 4'h8, 32'h0,    32'h0};
    tbl[6] = '{1'b1, 4'h8, 32'hFFFF, 32'h0};
    tbl[7] = '{1'b0, 4'h8, 32'h0,    32'h0};
    tbl[8] = '{1'b1, 4'hC, 32'h7,    32'h0};
    tbl[9] = '{1'b0, 4'h0, 32'h0,    32'h0};

    bus.addr = '0; bus.ren = 1'b0; bus.wen = 1'b0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_uart_tx", {31'b0, uart_tx}, 32'h1);
    check("reset_rx_irq", {31'b0, rx_irq}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // register-map vectors
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].wdata);
      else begin
        bus_read(tbl[i].addr, d);
        check($sformatf("vec%0d", i), d, tbl[i].exp);
      end
    end

    // single byte receive
    send_byte(8'hA5, 1'b1); sb.push_back(32'h1A5);
    check("a5_irq", {31'b0, rx_irq}, 32'h1);
    read_status("a5_status", st(1, 0, 0, 0, 0));
    read_rx("a5_read");
    read_rx("a5_empty_read");
    check("a5_irq_clear", {31'b0, rx_irq}, 32'h0);

    // 17 bytes, no reads: overrun
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(i), 1'b1);
      if (sb.size() < 16) sb.push_back(32'h100 | 32'(i));
    end
    read_status("ovr_status", st(16, 1, 0, 0, 0));
    repeat (5) @(negedge clk);
    check("rdata_hold", bus.rdata, st(16, 1, 0, 0, 0));
    bus_write(4'hC, 32'h1);
    read_status("ovr_cleared", st(16, 0, 0, 0, 0));

    // full FIFO, read coincident with push edge
    found = 1'b0;
    fork
      send_byte(8'h11, 1'b1);
      begin
        for (int i = 0; i < DIV * 12 && !found; i++) begin
          @(negedge clk);
          if (u_dut.u_rx.byte_valid_o) found = 1'b1;
        end
        if (found) begin
          bus.addr = 4'h0;
          bus.ren  = 1'b1;
          @(posedge clk);
          #1;
          bus.ren = 1'b0;
          check("coinc_read", bus.rdata, sb.pop_front());
          sb.push_back(32'h111);
        end
      end
    join
    check("coinc_push_seen", {31'b0, found}, 32'h1);
    read_status("coinc_status", st(16, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++) read_rx($sformatf("drain%0d", i));
    read_rx("drain_empty");

    // transmit 0x3C with a dropped mid-frame write
    txb = 8'h3C;
    check("tx_idle_high", {31'b0, uart_tx}, 32'h1);
    @(negedge clk);
    bus.addr = 4'h4; bus.wdata = 32'h3C; bus.wen = 1'b1;
    @(posedge clk);
    #1;
    bus.wen = 1'b0;
    e = cyc;
    check("tx_fall", {31'b0, uart_tx}, 32'h0);
    wait_until(e + HALF);
    check("tx_start_bit", {31'b0, uart_tx}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      wait_until(e + DIV * (i + 1) + HALF);
      check($sformatf("tx_bit%0d", i), {31'b0, uart_tx}, {31'b0, txb[i]});
      if (i == 3) begin
        bus_write(4'h4, 32'hFF);
        check("tx_drop_line", {31'b0, uart_tx}, {31'b0, txb[3]});
      end
      if (i == 5) read_status("tx_busy_status", st(0, 0, 0, 1, 1));
    end
    wait_until(e + DIV * 9 + HALF);
    check("tx_stop_bit", {31'b0, uart_tx}, 32'h1);
    wait_until(e + DIV * 10 + 1);
    read_status("tx_done_status", st(0, 0, 0, 1, 0));
    bus_write(4'hC, 32'h4);
    read_status("tx_drop_cleared", st(0, 0, 0, 0, 0));

    // 50-cycle glitch
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (50) @(negedge clk);
    uart_rx = 1'b1;
    repeat (400) @(negedge clk);
    read_status("glitch_status", st(0, 0, 0, 0, 0));

    // stop bit low
    send_byte(8'h55, 1'b0);
    repeat (DIV) @(negedge clk);
    read_status("ferr_status", st(0, 0, 1, 0, 0));
    bus_write(4'hC, 32'h2);
    read_status("ferr_cleared", st(0, 0, 0, 0, 0));

    // flush
    send_byte(8'h33, 1'b1); sb.push_back(32'h133);
    read_status("pre_flush", st(1, 0, 0, 0, 0));
    bus_write(4'hC, 32'h8); sb.delete();
    read_status("post_flush", st(0, 0, 0, 0, 0));
    read_rx("flush_empty_read");

    // reset mid-frame in both directions
    fork
      send_byte(8'hF8, 1'b1);
      begin
        bus_write(4'h4, 32'h00);
        repeat (480) @(posedge clk);
        #1;
        check("tx_low_pre_reset", {31'b0, uart_tx}, 32'h0);
        #2 rst_n = 1'b0;
        #1 check("tx_async_reset", {31'b0, uart_tx}, 32'h1);
        check("rdata_in_reset", bus.rdata, 32'h0);
        repeat (500) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (DIV) @(negedge clk);
    read_status("post_reset_status", st(0, 0, 0, 0, 0));
    send_byte(8'h96, 1'b1); sb.push_back(32'h196);
    read_rx("post_reset_rx");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
